display_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the clock display; drives one shared 74LS47-style BCD-to-7-segment decoder across NUM_DIGITS common-anode digits (HH:MM:SS).
- Double-buffers the digit values and loads them only at frame boundaries, so the display never tears.
- Provides an anti-ghosting blank gap, 16-level brightness PWM, leading-zero blanking and invalid-BCD blanking.
- Sits between the timekeeping counters and the decoder/digit drivers.

---
 rtl/display_scan_ctrl_pkg.sv | 21 ++
 rtl/display_scan_ctrl_lz_blank_mask.sv | 24 ++
 rtl/display_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and helpers for the display scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    S_BLANK,
    S_ON,
    S_OFF
  } state_e;

  localparam int BCD_MAX    = 9;
  localparam int PWM_LEVELS = 16;

  function automatic int on_cycles(input logic [3:0] b, input int unit);
    return (int'({1'b0, b}) + 1) * unit;
  endfunction

  function automatic int off_cycles(input logic [3:0] b, input int unit);
    return (PWM_LEVELS - 1 - int'({1'b0, b})) * unit;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_lz_blank_mask.sv
// Per-digit blank mask: invalid BCD nibbles, plus leading zeros when enabled.
module lz_blank_mask
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    blank_lz_i,
  output logic [NUM_DIGITS-1:0]   mask_o
);

  always_comb begin
    logic zero_above;
    mask_o     = '0;
    zero_above = 1'b1;
    // Walk from the most significant digit down; digit 0 always stays lit.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (digits_i[4*i +: 4] == 4'd0);
      mask_o[i]  = (digits_i[4*i +: 4] > 4'(BCD_MAX)) ||
                   (blank_lz_i && zero_above && (i != 0));
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous double buffering and PWM dimming.
// Optional lamp-test input is enabled by defining LAMP_TEST_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int BLANK_CYCLES = 16,
  parameter int UNIT_CYCLES  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic                    load,
  input  logic [3:0]              brightness,
  input  logic                    blank_lz,
`ifdef LAMP_TEST_EN
  input  logic                    lamp_test,
`endif
  output logic [3:0]              bcd_out,
  output logic                    bi_n,
  output logic                    lt_n,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int SLOT = BLANK_CYCLES + PWM_LEVELS * UNIT_CYCLES;
  localparam int CW   = $clog2(SLOT);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e                  state_q;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           pos_q, pos_d;
  logic [CW-1:0]           on_len_q, off_len_q;
  logic [4*NUM_DIGITS-1:0] shadow_q, pending_q;
  logic                    pending_valid_q;
  logic [3:0]              bcd_q;
  logic                    bi_n_q, lt_n_q, frame_done_q;
  logic [NUM_DIGITS-1:0]   dig_en_q;

  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              nib;
  logic                    slot_end;
  logic                    lamp_s;

`ifdef LAMP_TEST_EN
  assign lamp_s = lamp_test;
`else
  assign lamp_s = 1'b0;
`endif

  lz_blank_mask #(.NUM_DIGITS(NUM_DIGITS)) u_mask (
    .digits_i   (shadow_q),
    .blank_lz_i (blank_lz),
    .mask_o     (blank_mask)
  );

  assign nib      = shadow_q[4*idx_q +: 4];
  assign slot_end = (pos_q == CW'(SLOT - 1));
  assign pos_d    = slot_end ? '0 : pos_q + CW'(1);
  assign idx_d    = !slot_end ? idx_q :
                    (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_BLANK;
      idx_q           <= '0;
      pos_q           <= '0;
      on_len_q        <= '0;
      off_len_q       <= '0;
      shadow_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      bcd_q           <= '0;
      bi_n_q          <= 1'b0;
      lt_n_q          <= 1'b1;
      dig_en_q        <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      idx_q        <= idx_d;
      // Registered, so it is armed one cycle ahead of the frame's last cycle.
      frame_done_q <= (idx_q == IW'(NUM_DIGITS - 1)) && (pos_q == CW'(SLOT - 2));

      case (state_q)
        S_BLANK: begin
          if (pos_q == '0) begin
            bcd_q     <= nib;
            bi_n_q    <= lamp_s | ~blank_mask[idx_q];
            lt_n_q    <= ~lamp_s;
            on_len_q  <= CW'(on_cycles(brightness, UNIT_CYCLES));
            off_len_q <= CW'(off_cycles(brightness, UNIT_CYCLES));
          end
          if (pos_q == CW'(BLANK_CYCLES - 1)) begin
            state_q  <= S_ON;
            dig_en_q <= NUM_DIGITS'(1) << idx_q;
          end
        end
        S_ON: begin
          if (pos_q == CW'(BLANK_CYCLES) + on_len_q - CW'(1)) begin
            dig_en_q <= '0;
            state_q  <= (off_len_q == '0) ? S_BLANK : S_OFF;
          end
        end
        S_OFF: begin
          if (slot_end) state_q <= S_BLANK;
        end
        default: state_q <= S_BLANK;
      endcase

      // A load landing on the boundary cycle goes straight to the shadow.
      if (frame_done_q) begin
        if (load) shadow_q <= digits_bcd;
        else if (pending_valid_q) shadow_q <= pending_q;
        pending_valid_q <= 1'b0;
      end else if (load) begin
        pending_q       <= digits_bcd;
        pending_valid_q <= 1'b1;
      end
    end
  end

  assign bcd_out    = bcd_q;
  assign bi_n       = bi_n_q;
  assign lt_n       = lt_n_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a frame-level model predicts each slot, a monitor measures it.
module tb_display_scan_ctrl;

  localparam int ND    = 6;
  localparam int BC    = 4;
  localparam int UC    = 2;
  localparam int SLOT  = BC + 16 * UC;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [23:0]   digits_bcd = '0;
  logic          load = 1'b0;
  logic [3:0]    brightness = '0;
  logic          blank_lz = 1'b0;
`ifdef LAMP_TEST_EN
  logic          lamp_test = 1'b0;
`endif
  logic [3:0]    bcd_out;
  logic          bi_n, lt_n;
  logic [ND-1:0] dig_en;
  logic          frame_done;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NUM_DIGITS(ND), .BLANK_CYCLES(BC), .UNIT_CYCLES(UC)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_bcd (digits_bcd),
    .load       (load),
    .brightness (brightness),
    .blank_lz   (blank_lz),
`ifdef LAMP_TEST_EN
    .lamp_test  (lamp_test),
`endif
    .bcd_out    (bcd_out),
    .bi_n       (bi_n),
    .lt_n       (lt_n),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  typedef struct {
    int idx;
    int bcd;
    bit bi_n;
    bit lt_n;
    int on_len;
    int rise;
  } slot_t;

  slot_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    slots_done = 0;

  int    m_sh[ND];
  int    m_pend[ND];
  bit    m_pv;
  int    cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Number of significant digits in the displayed value (at least one).
  function automatic int sig_digits();
    int s = 1;
    for (int j = 0; j < ND; j++) if (m_sh[j] != 0) s = j + 1;
    return s;
  endfunction

  task automatic model_cycle();
    int    pos  = cyc % SLOT;
    int    slot = (cyc / SLOT) % ND;
    bit    lt   = 1'b0;
    slot_t e;
`ifdef LAMP_TEST_EN
    lt = lamp_test;
`endif
    if (pos == 0) begin
      e.idx    = slot;
      e.bcd    = m_sh[slot];
      e.lt_n   = !lt;
      e.bi_n   = lt || !((m_sh[slot] > 9) || (blank_lz && slot >= sig_digits()));
      e.on_len = (int'(brightness) + 1) * UC;
      e.rise   = cyc + BC;
      exp_q.push_back(e);
    end
    if (cyc % FRAME == FRAME - 1) begin
      if (load) begin
        for (int j = 0; j < ND; j++) m_sh[j] = int'(digits_bcd[4*j +: 4]);
      end else if (m_pv) begin
        m_sh = m_pend;
      end
      m_pv = 1'b0;
    end else if (load) begin
      for (int j = 0; j < ND; j++) m_pend[j] = int'(digits_bcd[4*j +: 4]);
      m_pv = 1'b1;
    end
  endtask

  task automatic tick();
    model_cycle();
    @(negedge clk);
    load = 1'b0;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_to(input int p);
    do tick(); while (cyc % FRAME != p);
  endtask

  task automatic do_load(input logic [23:0] d);
    digits_bcd = d;
    load       = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_dig_en", dig_en, 0);
    check("rst_bi_n", bi_n, 0);
    check("rst_bcd_out", bcd_out, 0);
    check("rst_lt_n", lt_n, 1);
    check("rst_frame_done", frame_done, 0);
    exp_q.delete();
    for (int j = 0; j < ND; j++) begin
      m_sh[j]   = 0;
      m_pend[j] = 0;
    end
    m_pv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cyc = 0;
  endtask

  function automatic logic [23:0] rand_digits();
    logic [23:0] v;
    int          top = $urandom_range(1, ND);
    v = '0;
    for (int j = 0; j < top; j++) begin
      v[4*j +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin : monitor
    int          mcyc;
    logic [ND-1:0] prev;
    slot_t       got;
    slot_t       e;
    mcyc = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mcyc = 0;
        prev = '0;
        continue;
      end
      check("frame_done", frame_done, (mcyc % FRAME) == FRAME - 1);
      if (dig_en != 0 && prev == 0) begin
        check("dig_en_onehot", $countones(dig_en), 1);
        for (int j = 0; j < ND; j++) if (dig_en[j]) got.idx = j;
        got.rise   = mcyc;
        got.bcd    = int'(bcd_out);
        got.bi_n   = bi_n;
        got.lt_n   = lt_n;
        got.on_len = 1;
      end else if (dig_en != 0) begin
        check("dig_en_stable", dig_en, prev);
        got.on_len++;
      end else if (prev != 0) begin
        if (exp_q.size() == 0) begin
          check("slot_expected", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("slot_digit", got.idx, e.idx);
          check("slot_rise_cycle", got.rise, e.rise);
          check("slot_bcd_out", got.bcd, e.bcd);
          check("slot_bi_n", got.bi_n, e.bi_n);
          check("slot_lt_n", got.lt_n, e.lt_n);
          check("slot_on_len", got.on_len, e.on_len);
          slots_done++;
        end
      end
      prev = dig_en;
      mcyc++;
    end
  end

  initial begin : stimulus
    cyc = 0;
    apply_reset();

    // Basic display at full brightness.
    brightness = 4'd15;
    do_load(24'h123456);
    run(3 * FRAME);

    // Minimum brightness, then a change in the middle of an ON phase.
    brightness = 4'd0;
    run_to(0);
    run(FRAME);
    run_to(SLOT + BC + 1);
    brightness = 4'd7;
    run(2 * FRAME);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(24'h000045);
    run(2 * FRAME);
    do_load(24'h000000);
    run(2 * FRAME);
    blank_lz = 1'b0;

    // Two loads in one frame, then a load on the boundary cycle.
    run_to(50);
    do_load(24'h111111);
    run_to(120);
    do_load(24'h222222);
    run_to(FRAME - 1);
    do_load(24'h333333);
    run(2 * FRAME);

    // Invalid nibble in digit 3.
    brightness = 4'd9;
    do_load(24'h12A456);
    run(2 * FRAME);

`ifdef LAMP_TEST_EN
    lamp_test = 1'b1;
    blank_lz  = 1'b1;
    do_load(24'h00B000);
    run(2 * FRAME);
    lamp_test = 1'b0;
    run(FRAME);
    blank_lz  = 1'b0;
`endif

    // Randomised loads, brightness and blanking, including boundary-cycle loads.
    repeat (20 * FRAME) begin
      if ($urandom_range(0, 149) == 0 ||
          ((cyc % FRAME == FRAME - 1) && $urandom_range(0, 1) == 0))
        do_load(rand_digits());
      if ($urandom_range(0, 99) == 0) brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) blank_lz = ~blank_lz;
      tick();
    end

    // Reset while digit 2 is lit.
    blank_lz   = 1'b0;
    brightness = 4'd15;
    run_to(0);
    run_to(2 * SLOT + 10);
    check("pre_reset_dig_en", dig_en, 6'b000100);
    apply_reset();
    do_load(24'h654321);
    run(3 * FRAME);

    check("slots_seen_min", slots_done >= 150, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
